// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared widths, aluop/alusel encodings and constants for the execute stage
package ex_stage_pkg;
  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  localparam logic [DATA_W-1:0] ZERO_WORD     = '0;
  localparam logic              RST_ENABLE    = 1'b1;
  localparam logic              WRITE_ENABLE  = 1'b1;
  localparam logic              WRITE_DISABLE = 1'b0;
  localparam logic [REG_AW-1:0] NOP_REG_ADDR  = '0;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_SLLV_OP = 8'b0000_0100;
  localparam logic [ALUOP_W-1:0] EXE_SRLV_OP = 8'b0000_0110;
  localparam logic [ALUOP_W-1:0] EXE_SRAV_OP = 8'b0000_0111;
  localparam logic [ALUOP_W-1:0] EXE_MOVZ_OP = 8'b0000_1010;
  localparam logic [ALUOP_W-1:0] EXE_MOVN_OP = 8'b0000_1011;
  localparam logic [ALUOP_W-1:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [ALUOP_W-1:0] EXE_MTHI_OP = 8'b0001_0001;
  localparam logic [ALUOP_W-1:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [ALUOP_W-1:0] EXE_MTLO_OP = 8'b0001_0011;

  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = 3'b011;

  typedef enum logic [1:0] {
    SHIFT_LL = 2'd0,
    SHIFT_RL = 2'd1,
    SHIFT_RA = 2'd2
  } shift_mode_e;
endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - decode-to-execute operation bus, pipeline control and EX/MEM outputs
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [ALUOP_W-1:0]  aluop_i;
  logic [ALUSEL_W-1:0] alusel_i;
  logic [DATA_W-1:0]   reg1_i;
  logic [DATA_W-1:0]   reg2_i;
  logic [REG_AW-1:0]   wd_i;
  logic                wreg_i;
  logic                stall_i;
  logic                flush_i;
  logic [DATA_W-1:0]   ex_wdata_o;
  logic [REG_AW-1:0]   ex_wd_o;
  logic                ex_wreg_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [REG_AW-1:0]   mem_wd_o;
  logic                mem_wreg_o;
  logic [DATA_W-1:0]   hi_o;
  logic [DATA_W-1:0]   lo_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i, flush_i,
    input  ex_wdata_o, ex_wd_o, ex_wreg_o, mem_wdata_o, mem_wd_o, mem_wreg_o, hi_o, lo_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i, flush_i,
    output ex_wdata_o, ex_wd_o, ex_wreg_o, mem_wdata_o, mem_wd_o, mem_wreg_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_shifter.sv
// rtl/ex_shifter.sv - combinational 32-bit barrel shifter (logical left, logical right, arithmetic right)
module ex_shifter
  import ex_stage_pkg::*;
(
  input  logic [DATA_W-1:0] value_i,
  input  logic [4:0]        amount_i,
  input  shift_mode_e       mode_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = value_i;
    case (mode_i)
      SHIFT_LL: result_o = value_i << amount_i;
      SHIFT_RL: result_o = value_i >> amount_i;
      SHIFT_RA: result_o = $signed(value_i) >>> amount_i;
      default:  result_o = value_i;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU result, HI/LO registers, EX forwarding and EX/MEM register
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus
);

  logic [DATA_W-1:0] logic_res;
  logic [DATA_W-1:0] shift_raw;
  logic [DATA_W-1:0] shift_res;
  logic [DATA_W-1:0] move_res;
  logic [DATA_W-1:0] result;
  logic              shift_hit;
  shift_mode_e       shift_mode;

  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic [REG_AW-1:0] mem_wd_d, mem_wd_q;
  logic              mem_wreg_d, mem_wreg_q;
  logic [DATA_W-1:0] hi_d, hi_q;
  logic [DATA_W-1:0] lo_d, lo_q;
  logic              advance;

  ex_shifter u_shifter (
    .value_i  (bus.reg2_i),
    .amount_i (bus.reg1_i[4:0]),
    .mode_i   (shift_mode),
    .result_o (shift_raw)
  );

  always_comb begin
    logic_res  = ZERO_WORD;
    shift_mode = SHIFT_LL;
    shift_hit  = 1'b0;
    move_res   = ZERO_WORD;
    case (bus.aluop_i)
      EXE_AND_OP: logic_res = bus.reg1_i & bus.reg2_i;
      EXE_OR_OP:  logic_res = bus.reg1_i | bus.reg2_i;
      EXE_XOR_OP: logic_res = bus.reg1_i ^ bus.reg2_i;
      EXE_NOR_OP: logic_res = ~(bus.reg1_i | bus.reg2_i);
      default:    logic_res = ZERO_WORD;
    endcase
    case (bus.aluop_i)
      EXE_SLL_OP, EXE_SLLV_OP: begin shift_mode = SHIFT_LL; shift_hit = 1'b1; end
      EXE_SRL_OP, EXE_SRLV_OP: begin shift_mode = SHIFT_RL; shift_hit = 1'b1; end
      EXE_SRA_OP, EXE_SRAV_OP: begin shift_mode = SHIFT_RA; shift_hit = 1'b1; end
      default:                 shift_hit = 1'b0;
    endcase
    // MOVZ/MOVN condition was already folded into wreg_i by decode
    case (bus.aluop_i)
      EXE_MOVZ_OP, EXE_MOVN_OP: move_res = bus.reg1_i;
      EXE_MFHI_OP:              move_res = hi_q;
      EXE_MFLO_OP:              move_res = lo_q;
      default:                  move_res = ZERO_WORD;
    endcase
  end

  assign shift_res = shift_hit ? shift_raw : ZERO_WORD;

  always_comb begin
    result = ZERO_WORD;
    case (bus.alusel_i)
      EXE_RES_LOGIC: result = logic_res;
      EXE_RES_SHIFT: result = shift_res;
      EXE_RES_MOVE:  result = move_res;
      default:       result = ZERO_WORD;
    endcase
  end

  assign bus.ex_wdata_o = (rst == RST_ENABLE) ? ZERO_WORD     : result;
  assign bus.ex_wd_o    = (rst == RST_ENABLE) ? NOP_REG_ADDR  : bus.wd_i;
  assign bus.ex_wreg_o  = (rst == RST_ENABLE) ? WRITE_DISABLE : bus.wreg_i;

  assign advance = !bus.stall_i && !bus.flush_i;

  always_comb begin
    mem_wdata_d = mem_wdata_q;
    mem_wd_d    = mem_wd_q;
    mem_wreg_d  = mem_wreg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (bus.flush_i) begin
      mem_wdata_d = ZERO_WORD;
      mem_wd_d    = NOP_REG_ADDR;
      mem_wreg_d  = WRITE_DISABLE;
    end else if (!bus.stall_i) begin
      mem_wdata_d = result;
      mem_wd_d    = bus.wd_i;
      mem_wreg_d  = bus.wreg_i;
    end
    // a stalled MTHI/MTLO retries each cycle and lands on the first free edge
    if (advance && bus.aluop_i == EXE_MTHI_OP) hi_d = bus.reg1_i;
    if (advance && bus.aluop_i == EXE_MTLO_OP) lo_d = bus.reg1_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wdata_q <= ZERO_WORD;
      mem_wd_q    <= NOP_REG_ADDR;
      mem_wreg_q  <= WRITE_DISABLE;
      hi_q        <= ZERO_WORD;
      lo_q        <= ZERO_WORD;
    end else begin
      mem_wdata_q <= mem_wdata_d;
      mem_wd_q    <= mem_wd_d;
      mem_wreg_q  <= mem_wreg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_wd_o    = mem_wd_q;
  assign bus.mem_wreg_o  = mem_wreg_q;
  assign bus.hi_o        = hi_q;
  assign bus.lo_o        = lo_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the decoded operation from instruction decode (aluop, alusel, reg1, reg2, wd, wreg) and computes the write-back result.
- Owns the HI/LO architectural registers.
- Drives the combinational EX forwarding path back to decode.
- Registers the result into the EX/MEM pipeline register.

Parameters:
- DATA_W, 32, operand/result/HI/LO width
- REG_AW, 5, register address width
- ALUOP_W, 8, aluop width
- ALUSEL_W, 3, alusel width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- aluop_i  in  8  operation code from decode
- alusel_i  in  3  result class from decode
- reg1_i  in  32  operand 1 (rs, or imm / shamt)
- reg2_i  in  32  operand 2 (rt, or imm)
- wd_i  in  5  destination register
- wreg_i  in  1  destination write enable
- stall_i  in  1  hold EX/MEM register, suppress HI/LO update
- flush_i  in  1  load bubble into EX/MEM register, suppress HI/LO update
- ex_wdata_o  out  32  combinational result (forwarding to decode)
- ex_wd_o  out  5  combinational = wd_i
- ex_wreg_o  out  1  combinational = wreg_i
- mem_wdata_o  out  32  registered result
- mem_wd_o  out  5  registered destination
- mem_wreg_o  out  1  registered write enable
- hi_o  out  32  current HI
- lo_o  out  32  current LO

Behaviour:
- Reset (async, rst=1): mem_wdata_o=0, mem_wd_o=0, mem_wreg_o=0, hi_o=0, lo_o=0.
  - Combinational ex_* outputs forced to 0 while rst=1.
  - Deassertion takes effect at the next clk edge; no partial state survives.
- Aluop encodings:
  - NOP 00000000
  - Logic: AND 00100100, OR 00100101, XOR 00100110, NOR 00100111
  - Shift: SLL 01111100, SRL 00000010, SRA 00000011, SLLV 00000100, SRLV 00000110, SRAV 00000111
  - Move: MOVZ 00001010, MOVN 00001011, MFHI 00010000, MTHI 00010001, MFLO 00010010, MTLO 00010011
- Alusel encodings: NOP 000, LOGIC 001, SHIFT 010, MOVE 011.
- Logic results: reg1 op reg2, bitwise, 32-bit.
- Shift results: value = reg2_i, amount = reg1_i[4:0]; upper bits of reg1 ignored.
  - SLL/SLLV: logical left.
  - SRL/SRLV: logical right.
  - SRA/SRAV: arithmetic right, sign = reg2_i[31].
  - Shift amount 0 returns reg2 unchanged.
- Move results: MOVZ/MOVN -> reg1_i; MFHI -> HI; MFLO -> LO.
  - The move condition is already resolved by decode in wreg_i; this block passes wreg_i through unchanged.
- Result select by alusel_i: LOGIC/SHIFT/MOVE pick the respective result; NOP and undefined codes give 0.
  - An aluop not matching its class gives 0. wreg_i is still passed through.
- EX/MEM register, priority rst > flush > stall > load:
  - flush_i=1: next cycle mem_wreg_o=0, mem_wd_o=0, mem_wdata_o=0.
  - stall_i=1 (no flush): all mem_* hold.
  - Otherwise: load ex_wdata, wd_i, wreg_i. Latency 1 cycle.
- HI/LO:
  - MTHI writes HI<=reg1_i at the clk edge ending the EX cycle; MTLO writes LO likewise.
  - Write happens only when stall_i=0, flush_i=0, rst=0.
  - MTHI/MTLO do not alter mem_wreg_o semantics (decode sends wreg=0).
- HI/LO ordering:
  - MTHI then MFHI in the following cycle: MFHI returns the new value. No extra bypass needed, since the write is complete at the edge.
  - A stalled MTHI writes once, on the first non-stalled edge.
  - A flushed MTHI never writes.
- Combinational ex_* outputs are valid regardless of stall/flush; decode qualifies them.

Decomposition:
- Shared package/define file: aluop and alusel encodings, ZeroWord, RstEnable, WriteEnable/Disable, NOPRegAddr, bus widths. These are the same constants decode uses.
- One natural sub-module, ex_shifter: combinational 32-bit barrel shifter (value, amount, mode) -> result.
- Everything else stays in ex_stage.

Test Plan:
- Reset: assert rst mid-run with mem_wreg_o=1, hi_o=0x1234 -> immediately (async) all mem_*, hi_o, lo_o = 0.
- Logic ops: OR reg1=0x0000FF00 reg2=0x00FF0000 wd=5 wreg=1 -> next cycle mem_wdata_o=0x00FFFF00, mem_wd_o=5, mem_wreg_o=1.
  - NOR of same operands -> 0xFF0000FF.
- Shifts: SRA reg1=4 reg2=0x80000010 -> 0xF8000001; SRL -> 0x08000001; SLLV reg1=0xFFFFFF21 reg2=1 -> 0x00000002.
- HI/LO: MTHI reg1=0xDEADBEEF, next cycle MFHI wd=3 wreg=1 -> ex_wdata_o=0xDEADBEEF that cycle, mem_wdata_o=0xDEADBEEF one cycle later. Repeat for MTLO/MFLO.
- Stall/flush: MTLO 0x55 with stall_i=1 for 2 cycles -> lo_o and mem_* unchanged; on release, lo_o=0x55.
  - MTHI 0x77 with flush_i=1 and stall_i=1 -> hi_o unchanged, mem_wreg_o=0.
- Undefined alusel 111 with wreg_i=1, wd=9 -> mem_wdata_o=0, mem_wreg_o=1, mem_wd_o=9.
